cpu_irq_ctrl: RTL

- Parametrised interrupt front-end for the cpu subsystem. Replaces the tied-off irq_ack_o/irq_id_o with a real claim/acknowledge path.
- Per line, it either latches edge-sensitive requests or passes level-sensitive requests through. It applies an enable mask and selects the highest-priority pending line.
- It presents the selected ID on a req/ack handshake held stable until the core acknowledges, then echoes the acknowledge to the system side.
- Sits between the peripheral/CLINT interrupt sources and the core's irq inputs.

---
 rtl/cpu_irq_ctrl_pkg.sv | 17 +
 rtl/cpu_irq_ctrl_if.sv | 11 +
 rtl/cpu_irq_prio_enc.sv | 24 ++
 rtl/cpu_irq_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_irq_ctrl_pkg.sv
// rtl/cpu_irq_ctrl_pkg.sv - shared types, core edge map and ID width helper for the interrupt front-end
package cpu_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

    // software=3, timer=7, external=11 and fast lines 31:16 latch on edges
    localparam logic [31:0] CORE_EDGE_MASK = 32'hFFFF_0888;

    function automatic int irq_id_w(input int num_irq);
        return (num_irq > 2) ? $clog2(num_irq) : 1;
    endfunction

endpackage

// File: rtl/cpu_irq_ctrl_if.sv
// rtl/cpu_irq_ctrl_if.sv - core-side interrupt request/acknowledge handshake
interface cpu_irq_ctrl_if #(
    parameter int ID_W = 5
);
    logic            irq_req_o;
    logic [ID_W-1:0] irq_id_o;
    logic            irq_ack_i;

    modport master (output irq_req_o, output irq_id_o, input irq_ack_i);
    modport slave  (input irq_req_o, input irq_id_o, output irq_ack_i);
endinterface

// File: rtl/cpu_irq_prio_enc.sv
// rtl/cpu_irq_prio_enc.sv - combinational highest-index-wins priority encoder
module cpu_irq_prio_enc
    import cpu_irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = irq_id_w(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_irq_ctrl.sv
// rtl/cpu_irq_ctrl.sv - interrupt front-end with claim/ack path; CPU_IRQ_CTRL_LAT_STATS_EN adds req-to-ack latency stats
module cpu_irq_ctrl
    import cpu_irq_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ   = 32,
    parameter int                 ID_W      = irq_id_w(NUM_IRQ),
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
    parameter int                 LAT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_IRQ-1:0]   irq_i,
    input  logic [NUM_IRQ-1:0]   irq_en_i,
    input  logic [NUM_IRQ-1:0]   irq_clr_i,
    output logic [NUM_IRQ-1:0]   irq_pending_o,
    cpu_irq_ctrl_if.master       core,
    output logic                 irq_ack_o,
    output logic [ID_W-1:0]      irq_ack_id_o,
    output logic                 wake_o,
    output logic [LAT_W-1:0]     lat_max_o
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;
    logic               ack_take;
    irq_state_e         state;

    assign cand          = pending & irq_en_i;
    assign wake_o        = |cand;
    assign irq_pending_o = pending;
    assign ack_take      = (state == REQ) && core.irq_ack_i;

    cpu_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (cand),
        .id    (win_id),
        .valid (win_vld)
    );

    always_comb begin
        ack_clr = '0;
        if (ack_take) begin
            ack_clr[core.irq_id_o] = 1'b1;
        end
    end

    // new edges override clears landing in the same cycle
    always_comb begin
        pending_nxt = (EDGE_MASK & ((irq_i & ~irq_q) | (pending & ~(irq_clr_i | ack_clr))))
                    | (~EDGE_MASK & irq_i);
    end

    // history resets high so a line already asserted at release is not an edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q   <= '1;
            pending <= '0;
        end else begin
            irq_q   <= irq_i;
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            core.irq_req_o <= 1'b0;
            core.irq_id_o  <= '0;
            irq_ack_o      <= 1'b0;
            irq_ack_id_o   <= '0;
        end else begin
            irq_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        core.irq_id_o  <= win_id;
                        core.irq_req_o <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        core.irq_req_o <= 1'b0;
                        irq_ack_o      <= 1'b1;
                        irq_ack_id_o   <= core.irq_id_o;
                        state          <= GAP;
                    end else if (!cand[core.irq_id_o]) begin
                        core.irq_req_o <= 1'b0;
                        state          <= IDLE;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    core.irq_req_o <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

`ifdef CPU_IRQ_CTRL_LAT_STATS_EN
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_inc;
    logic [LAT_W-1:0] lat_max;

    // lat_inc counts the current REQ cycle, so the ack cycle itself is included
    assign lat_inc   = (&lat_cnt) ? lat_cnt : lat_cnt + 1'b1;
    assign lat_max_o = lat_max;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_cnt <= '0;
            lat_max <= '0;
        end else if (state == IDLE && win_vld) begin
            lat_cnt <= '0;
        end else if (state == REQ) begin
            if (ack_take) begin
                if (lat_inc > lat_max) begin
                    lat_max <= lat_inc;
                end
            end else begin
                lat_cnt <= lat_inc;
            end
        end
    end
`else
    assign lat_max_o = '0;
`endif

endmodule
